// File: rtl/clk_div_bank_pkg.sv
// Shared constants and types for the clock divider bank.
package clk_div_bank_pkg;

    localparam int DEF_DIV_DEFAULT = 100;
    localparam int MAX_NCH         = 16;

    // Single-bit state carried by every divider channel
    typedef struct packed {
        logic pending;
        logic tick;
        logic clk_out;
    } chan_state_t;

    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/clk_div_bank_if.sv
// Divisor-write bus of the clock divider bank.
interface clk_div_bank_if
    import clk_div_bank_pkg::*;
#(
    parameter int NCH   = 4,
    parameter int DIV_W = 16
);
    localparam int CH_W = ch_width(NCH);

    logic             cfg_valid;
    logic [CH_W-1:0]  cfg_ch;
    logic [DIV_W-1:0] cfg_div;
    logic             cfg_ready;

    modport master (output cfg_valid, cfg_ch, cfg_div, input cfg_ready);
    modport slave  (input cfg_valid, cfg_ch, cfg_div, output cfg_ready);
endinterface

// File: rtl/clk_div_bank_chan.sv
// One divider channel: up-counter, glitch-free divisor update, tick and square wave.
// Optional 16-bit tick counter when CLK_DIV_BANK_CNT_EN is defined.
module clk_div_chan
    import clk_div_bank_pkg::*;
#(
    parameter int DIV_W   = 16,
    parameter int DEF_DIV = DEF_DIV_DEFAULT
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             en,
    input  logic             wr,
    input  logic [DIV_W-1:0] wr_div,
    output logic             pending,
    output logic             tick,
    output logic             clk_out
`ifdef CLK_DIV_BANK_CNT_EN
    ,
    output logic [15:0]      tick_cnt
`endif
);

    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] div;
    logic [DIV_W-1:0] pend_div;
    chan_state_t      st;
    logic             running;
    logic             wrap;

    assign running = en && (div != '0);
    assign wrap    = running && (cnt == div - DIV_W'(1));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt      <= '0;
            div      <= DIV_W'(DEF_DIV);
            pend_div <= '0;
            st       <= '0;
        end else begin
            st.tick <= wrap;
            if (wrap) begin
                st.clk_out <= ~st.clk_out;
            end
            // A stalled channel has no wrap to wait for, so take the new divisor now
            if (st.pending && (wrap || !running)) begin
                div        <= pend_div;
                cnt        <= '0;
                st.pending <= 1'b0;
            end else if (wrap || (div == '0)) begin
                cnt <= '0;
            end else if (en) begin
                cnt <= cnt + DIV_W'(1);
            end
            if (wr) begin
                pend_div   <= wr_div;
                st.pending <= 1'b1;
            end
        end
    end

    assign pending = st.pending;
    assign tick    = st.tick;
    assign clk_out = st.clk_out;

`ifdef CLK_DIV_BANK_CNT_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tick_cnt <= '0;
        end else if (wrap) begin
            tick_cnt <= tick_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: rtl/clk_div_bank.sv
// Bank of NCH independent clock dividers with a shared divisor-write port.
// Optional per-channel tick counters when CLK_DIV_BANK_CNT_EN is defined.
module clk_div_bank
    import clk_div_bank_pkg::*;
#(
    parameter int NCH     = 4,
    parameter int DIV_W   = 16,
    parameter int DEF_DIV = DEF_DIV_DEFAULT
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic [NCH-1:0]  ch_en,
    clk_div_bank_if.slave   cfg,
    output logic [NCH-1:0]  tick,
    output logic [NCH-1:0]  clk_out
`ifdef CLK_DIV_BANK_CNT_EN
    ,
    output logic [NCH*16-1:0] tick_cnt
`endif
);

    logic [NCH-1:0] pending;
    logic [NCH-1:0] wr;
    logic           ready;
    logic           accept;

    // Out-of-range channel indices stay ready and write nothing
    always_comb begin
        ready = 1'b1;
        for (int i = 0; i < NCH; i++) begin
            if (int'(cfg.cfg_ch) == i) begin
                ready = !pending[i];
            end
        end
    end

    assign cfg.cfg_ready = ready;
    assign accept        = cfg.cfg_valid && ready;

    always_comb begin
        wr = '0;
        for (int i = 0; i < NCH; i++) begin
            wr[i] = accept && (int'(cfg.cfg_ch) == i);
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        clk_div_chan #(
            .DIV_W   (DIV_W),
            .DEF_DIV (DEF_DIV)
        ) u_chan (
            .clock    (clock),
            .reset_n  (reset_n),
            .en       (ch_en[i]),
            .wr       (wr[i]),
            .wr_div   (cfg.cfg_div),
            .pending  (pending[i]),
            .tick     (tick[i]),
            .clk_out  (clk_out[i])
`ifdef CLK_DIV_BANK_CNT_EN
            ,
            .tick_cnt (tick_cnt[i*16 +: 16])
`endif
        );
    end

endmodule

// File: tb/tb_clk_div_bank.sv
// Self-checking bench for clk_div_bank: period-countdown reference model plus directed scenarios.
module tb_clk_div_bank;

    localparam int NCH   = 5;
    localparam int DIV_W = 16;
    localparam int DEF   = 100;

    logic           clock;
    logic           reset_n;
    logic [NCH-1:0] ch_en;
    logic [NCH-1:0] tick;
    logic [NCH-1:0] clk_out;
`ifdef CLK_DIV_BANK_CNT_EN
    logic [NCH*16-1:0] tick_cnt;
`endif

    clk_div_bank_if #(.NCH(NCH), .DIV_W(DIV_W)) bus ();

    clk_div_bank #(.NCH(NCH), .DIV_W(DIV_W), .DEF_DIV(DEF)) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .ch_en    (ch_en),
        .cfg      (bus),
        .tick     (tick),
        .clk_out  (clk_out)
`ifdef CLK_DIV_BANK_CNT_EN
        ,
        .tick_cnt (tick_cnt)
`endif
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: each channel counts down the enabled cycles left in its period
    int             m_div  [NCH];
    int             m_rem  [NCH];
    int             m_pdiv [NCH];
    bit [NCH-1:0]   m_pend;
    logic [NCH-1:0] exp_tick;
    logic [NCH-1:0] exp_clk;
    logic [15:0]    m_tcnt [NCH];
    bit             m_acc;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cyc      = 0;
            m_pend   = '0;
            exp_tick = '0;
            exp_clk  = '0;
            for (int i = 0; i < NCH; i++) begin
                m_div[i]  = DEF;
                m_rem[i]  = DEF;
                m_pdiv[i] = 0;
                m_tcnt[i] = 16'd0;
            end
        end else begin
            cyc++;
            for (int i = 0; i < NCH; i++) begin
                m_acc       = bus.cfg_valid && !m_pend[i] && (int'(bus.cfg_ch) == i);
                exp_tick[i] = 1'b0;
                if (ch_en[i] && m_div[i] != 0) begin
                    m_rem[i]--;
                    if (m_rem[i] == 0) begin
                        exp_tick[i] = 1'b1;
                        exp_clk[i]  = ~exp_clk[i];
                        m_tcnt[i]   = m_tcnt[i] + 16'd1;
                        if (m_pend[i]) begin
                            m_div[i]  = m_pdiv[i];
                            m_pend[i] = 1'b0;
                        end
                        m_rem[i] = m_div[i];
                    end
                end else if (m_pend[i]) begin
                    m_div[i]  = m_pdiv[i];
                    m_pend[i] = 1'b0;
                    m_rem[i]  = m_div[i];
                end
                if (m_acc) begin
                    m_pend[i] = 1'b1;
                    m_pdiv[i] = int'(bus.cfg_div);
                end
            end
        end
    end

    always @(negedge clock) begin
        logic exp_rdy;
        exp_rdy = 1'b1;
        for (int i = 0; i < NCH; i++)
            if (int'(bus.cfg_ch) == i) exp_rdy = !m_pend[i];
        check("tick", 32'(tick), 32'(exp_tick));
        check("clk_out", 32'(clk_out), 32'(exp_clk));
        check("cfg_ready", 32'(bus.cfg_ready), 32'(exp_rdy));
`ifdef CLK_DIV_BANK_CNT_EN
        for (int i = 0; i < NCH; i++)
            check("tick_cnt", 32'(tick_cnt[i*16 +: 16]), 32'(m_tcnt[i]));
`endif
    end

    // Returns 2 time units after edge number n, when outputs of edge n are settled
    task automatic goto(input int n);
        while (cyc < n) begin
            @(posedge clock);
            #1;
        end
        #1;
    endtask

    task automatic cfg_write(input int ch, input int dv);
        bus.cfg_valid = 1'b1;
        bus.cfg_ch    = 3'(ch);
        bus.cfg_div   = 16'(dv);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n       = 1'b0;
        ch_en         = '0;
        bus.cfg_valid = 1'b0;
        bus.cfg_ch    = '0;
        bus.cfg_div   = '0;
        repeat (3) @(posedge clock);
        #2;
        check("rst tick", 32'(tick), 32'd0);
        check("rst clk_out", 32'(clk_out), 32'd0);
        check("rst cfg_ready", 32'(bus.cfg_ready), 32'd1);
        reset_n = 1'b1;
        ch_en   = '1;

        // Default divisor: first tick on edge 100, clk_out falls at 200
        goto(99);  check("s1 tick0@99", 32'(tick[0]), 32'd0);
        goto(100); check("s1 tick@100", 32'(tick), 32'h1f);
                   check("s1 clk@100", 32'(clk_out), 32'h1f);
        goto(200); check("s1 tick0@200", 32'(tick[0]), 32'd1);
                   check("s1 clk0@200", 32'(clk_out[0]), 32'd0);

        // ch1 div=3 while running
        cfg_write(1, 3);
        goto(201); bus.cfg_valid = 1'b0;
                   check("s2 ready@201", 32'(bus.cfg_ready), 32'd0);
        goto(299); check("s2 ready@299", 32'(bus.cfg_ready), 32'd0);
        goto(300); check("s2 ready@300", 32'(bus.cfg_ready), 32'd1);
                   check("s2 tick1@300", 32'(tick[1]), 32'd1);
        goto(302); check("s2 tick1@302", 32'(tick[1]), 32'd0);
        goto(303); check("s2 tick1@303", 32'(tick[1]), 32'd1);

        // ch0 write accepted on its wrap edge 400
        goto(399); cfg_write(0, 5);
        goto(400); bus.cfg_valid = 1'b0;
                   check("s3 tick0@400", 32'(tick[0]), 32'd1);
                   check("s3 ready@400", 32'(bus.cfg_ready), 32'd0);
        goto(499); check("s3 tick0@499", 32'(tick[0]), 32'd0);
        goto(500); check("s3 tick0@500", 32'(tick[0]), 32'd1);
        goto(504); check("s3 tick0@504", 32'(tick[0]), 32'd0);
        goto(505); check("s3 tick0@505", 32'(tick[0]), 32'd1);

        // ch2 div=1 then div=0
        goto(510); cfg_write(2, 1);
        goto(511); bus.cfg_valid = 1'b0;
        goto(600); check("s4 tick2@600", 32'(tick[2]), 32'd1);
        goto(601); check("s4 tick2@601", 32'(tick[2]), 32'd1);
                   check("s4 clk2@601", 32'(clk_out[2]), 32'd1);
        goto(602); check("s4 tick2@602", 32'(tick[2]), 32'd1);
                   check("s4 clk2@602", 32'(clk_out[2]), 32'd0);
                   cfg_write(2, 0);
        goto(603); bus.cfg_valid = 1'b0;
        goto(605); check("s4 tick2@605", 32'(tick[2]), 32'd0);

        // Write to a nonexistent channel
        goto(620); check("s4 clk2@620", 32'(clk_out[2]), 32'd0);
                   cfg_write(6, 9);
                   #1 check("s5 ready ch6", 32'(bus.cfg_ready), 32'd1);
        goto(621); bus.cfg_valid = 1'b0;

        // ch3 disabled at cnt=40 for 10 cycles
        goto(640); ch_en[3] = 1'b0;
        goto(645); check("s6 tick3@645", 32'(tick[3]), 32'd0);
                   check("s6 clk3@645", 32'(clk_out[3]), 32'd0);
        goto(650); ch_en[3] = 1'b1;
        goto(709); check("s6 tick3@709", 32'(tick[3]), 32'd0);
        goto(710); check("s6 tick3@710", 32'(tick[3]), 32'd1);
                   check("s6 clk3@710", 32'(clk_out[3]), 32'd1);

        // Reset mid-period with a pending write on ch3
        goto(720); cfg_write(3, 7);
        goto(721); bus.cfg_valid = 1'b0;
        goto(740); check("s7 ready@740", 32'(bus.cfg_ready), 32'd0);
        goto(750);
        #1 reset_n = 1'b0;
        #1;
        check("s7 rst tick", 32'(tick), 32'd0);
        check("s7 rst clk_out", 32'(clk_out), 32'd0);
        check("s7 rst ready", 32'(bus.cfg_ready), 32'd1);
        repeat (2) @(posedge clock);
        #2 reset_n = 1'b1;
        goto(99);  check("s7 tick3@99", 32'(tick[3]), 32'd0);
        goto(100); check("s7 tick@100", 32'(tick), 32'h1f);
                   check("s7 clk@100", 32'(clk_out), 32'h1f);
        goto(105); check("s7 tick@105", 32'(tick), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
